// File: rtl/seg7_scan_reader_pkg.sv
// Shared definitions for the 7-segment scan reader.
// Segment patterns are ordered a..g, with bit 0 = segment a.
package seg7_scan_reader_pkg;

    localparam logic [0:6] SEG_0     = 7'b1111110;
    localparam logic [0:6] SEG_1     = 7'b0110000;
    localparam logic [0:6] SEG_2     = 7'b1101101;
    localparam logic [0:6] SEG_3     = 7'b1111001;
    localparam logic [0:6] SEG_4     = 7'b0110011;
    localparam logic [0:6] SEG_5     = 7'b1011011;
    localparam logic [0:6] SEG_6     = 7'b1011111;
    localparam logic [0:6] SEG_7     = 7'b1110010;
    localparam logic [0:6] SEG_8     = 7'b1111111;
    localparam logic [0:6] SEG_9     = 7'b1111011;
    localparam logic [0:6] SEG_A     = 7'b1110111;
    localparam logic [0:6] SEG_B     = 7'b0011111;
    localparam logic [0:6] SEG_C     = 7'b1001110;
    localparam logic [0:6] SEG_D     = 7'b0111101;
    localparam logic [0:6] SEG_E     = 7'b1001111;
    localparam logic [0:6] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_scan_reader_decode.sv
// Combinational 7-segment pattern to hex nibble decoder.
// A blank pattern reads back as F; unknown patterns give 0 with err set.
module seg7_pattern_decode
    import seg7_scan_reader_pkg::*;
(
    input  logic [0:6] pattern_i,
    output logic [3:0] nibble_o,
    output logic       err_o
);

    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        case (pattern_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_BLANK: nibble_o = 4'hF;
            default:   err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a scanned multiplexed 7-segment display: waits for each strobed
// digit to settle, decodes it, and hands off complete frames on valid/ready.
module seg7_scan_reader
    import seg7_scan_reader_pkg::*;
#(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int COMMON_ANODE  = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:6]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] digits_out,
    output logic [NDIG-1:0]   err_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0]  SEL_ONE = NDIG'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [0:6]        seg_s1_q, seg_s2_q, seg_prev_q, seg_c;
    logic [NDIG-1:0]   sel_s1_q, sel_s2_q, sel_prev_q, sel_c;
    scan_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NDIG-1:0]   captured_q, captured_d;
    logic [4*NDIG-1:0] frame_q, frame_d, digits_q;
    logic [NDIG-1:0]   frame_err_q, frame_err_d, err_q;
    logic              valid_q, valid_d, overrun_q;

    logic              same, onehot, fire, complete, load;
    logic [IDX_W-1:0]  idx;
    scan_state_e       eval_state;
    logic [CNT_W-1:0]  eval_cnt;
    logic              eval_fire;
    logic [3:0]        dec_nibble;
    logic              dec_err;

    seg7_pattern_decode u_decode (
        .pattern_i (seg_c),
        .nibble_o  (dec_nibble),
        .err_o     (dec_err)
    );

    always_comb begin
        seg_c  = (COMMON_ANODE != 0) ? ~seg_s2_q : seg_s2_q;
        sel_c  = (COMMON_ANODE != 0) ? ~sel_s2_q : sel_s2_q;
        same   = (seg_c == seg_prev_q) && (sel_c == sel_prev_q);
        onehot = (sel_c != '0) && ((sel_c & (sel_c - SEL_ONE)) == '0);
        idx    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_c[i]) idx = IDX_W'(i);
        end
    end

    // Fresh look at the current sample, used whenever {seg,sel} changes.
    always_comb begin
        eval_state = ST_WAIT;
        eval_cnt   = '0;
        eval_fire  = 1'b0;
        if (onehot) begin
            eval_cnt = CNT_ONE;
            if (STABLE_CYCLES == 1) begin
                eval_fire  = 1'b1;
                eval_state = ST_DONE;
            end else begin
                eval_state = ST_SETTLE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                state_d = eval_state;
                cnt_d   = eval_cnt;
                fire    = eval_fire;
            end
            ST_SETTLE: begin
                if (same) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == CNT_MAX) begin
                        fire    = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = eval_state;
                    cnt_d   = eval_cnt;
                    fire    = eval_fire;
                end
            end
            ST_DONE: begin
                if (!same) begin
                    state_d = eval_state;
                    cnt_d   = eval_cnt;
                    fire    = eval_fire;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // A finished frame either loads, or is dropped with an overrun pulse.
    always_comb begin
        complete    = &captured_q;
        load        = complete && (!valid_q || out_ready);
        captured_d  = complete ? '0 : captured_q;
        frame_d     = frame_q;
        frame_err_d = frame_err_q;
        if (fire) begin
            captured_d[idx]       = 1'b1;
            frame_d[4*idx +: 4]   = dec_nibble;
            frame_err_d[idx]      = dec_err;
        end
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            seg_prev_q  <= '0;
            sel_prev_q  <= '0;
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            captured_q  <= '0;
            frame_q     <= '0;
            frame_err_q <= '0;
            digits_q    <= '0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            seg_s1_q    <= seg_in;
            seg_s2_q    <= seg_s1_q;
            sel_s1_q    <= dig_sel;
            sel_s2_q    <= sel_s1_q;
            seg_prev_q  <= seg_c;
            sel_prev_q  <= sel_c;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            frame_q     <= frame_d;
            frame_err_q <= frame_err_d;
            if (load) begin
                digits_q <= frame_q;
                err_q    <= frame_err_q;
            end
            valid_q     <= valid_d;
            overrun_q   <= complete && valid_q && !out_ready;
        end
    end

    assign digits_out = digits_q;
    assign err_out    = err_q;
    assign out_valid  = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench: common-cathode and common-anode readers with STABLE_CYCLES=4,
// plus a common-cathode reader with STABLE_CYCLES=1, all fed the same scan.
module tb_seg7_scan_reader;

    localparam logic [0:6] P0 = 7'b1111110;
    localparam logic [0:6] P1 = 7'b0110000;
    localparam logic [0:6] P2 = 7'b1101101;
    localparam logic [0:6] P3 = 7'b1111001;
    localparam logic [0:6] P4 = 7'b0110011;
    localparam logic [0:6] P5 = 7'b1011011;
    localparam logic [0:6] P6 = 7'b1011111;
    localparam logic [0:6] P7 = 7'b1110010;
    localparam logic [0:6] P8 = 7'b1111111;
    localparam logic [0:6] P9 = 7'b1111011;
    localparam logic [0:6] PA = 7'b1110111;
    localparam logic [0:6] PB = 7'b0011111;
    localparam logic [0:6] PC = 7'b1001110;
    localparam logic [0:6] PD = 7'b0111101;
    localparam logic [0:6] PE = 7'b1001111;
    localparam logic [0:6] PX = 7'b1000001;
    localparam logic [0:6] PO = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:6]  seg_v;
    logic [3:0]  sel_v;
    logic        ready;
    logic [0:6]  seg_inv;
    logic [3:0]  sel_inv;

    logic [15:0] d0, d1, d2;
    logic [3:0]  e0, e1, e2;
    logic        v0, v1, v2, o0, o1, o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign seg_inv = ~seg_v;
    assign sel_inv = ~sel_v;

    seg7_scan_reader #(.NDIG(4), .STABLE_CYCLES(4), .COMMON_ANODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_v), .dig_sel(sel_v),
        .digits_out(d0), .err_out(e0), .out_valid(v0), .out_ready(ready), .overrun(o0)
    );

    seg7_scan_reader #(.NDIG(4), .STABLE_CYCLES(4), .COMMON_ANODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_inv), .dig_sel(sel_inv),
        .digits_out(d1), .err_out(e1), .out_valid(v1), .out_ready(ready), .overrun(o1)
    );

    seg7_scan_reader #(.NDIG(4), .STABLE_CYCLES(1), .COMMON_ANODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_v), .dig_sel(sel_v),
        .digits_out(d2), .err_out(e2), .out_valid(v2), .out_ready(ready), .overrun(o2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] sel, input logic [0:6] seg);
        sel_v = sel;
        seg_v = seg;
    endtask

    // One strobe of 8 cycles followed by 2 blank cycles.
    task automatic digit(input int i, input logic [0:6] seg);
        drive(4'(1 << i), seg);
        cyc(8);
        drive(4'b0000, PO);
        cyc(2);
    endtask

    task automatic chk_both(input string tag, input logic [15:0] dig, input logic [3:0] err,
                            input logic vld, input logic ovr);
        chk({tag, " cc digits"},  32'(d0), 32'(dig));
        chk({tag, " cc err"},     32'(e0), 32'(err));
        chk({tag, " cc valid"},   32'(v0), 32'(vld));
        chk({tag, " cc overrun"}, 32'(o0), 32'(ovr));
        chk({tag, " ca digits"},  32'(d1), 32'(dig));
        chk({tag, " ca err"},     32'(e1), 32'(err));
        chk({tag, " ca valid"},   32'(v1), 32'(vld));
        chk({tag, " ca overrun"}, 32'(o1), 32'(ovr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ready = 1'b1;
        drive(4'b0000, PO);
        cyc(2);
        chk_both("reset", 16'h0000, 4'h0, 1'b0, 1'b0);
        chk("reset s1 valid", 32'(v2), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Scan 1,2,3,4; last digit applied before edge E1, capture at E6, valid after E7.
        digit(0, P1);
        digit(1, P2);
        digit(2, P3);
        drive(4'b1000, P4);
        cyc(4);
        chk("t1 s1 valid", 32'(v2), 32'd1);
        chk("t1 s1 digits", 32'(d2), 32'h4321);
        cyc(2);
        chk("t1 valid before", 32'(v0), 32'd0);
        chk("t1 ca valid before", 32'(v1), 32'd0);
        cyc(1);
        chk_both("t1 frame", 16'h4321, 4'h0, 1'b1, 1'b0);
        cyc(1);
        chk("t1 valid drop", 32'(v0), 32'd0);
        chk("t1 ca valid drop", 32'(v1), 32'd0);
        drive(4'b0000, PO);
        cyc(2);

        // Digit 0 toggles every 2 cycles, then holds the pattern for 4.
        digit(1, P5);
        digit(2, P6);
        digit(3, P7);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, (k % 2 == 0) ? P8 : P0);
            cyc(2);
        end
        chk("t2 no capture on toggle", 32'(v0), 32'd0);
        drive(4'b0001, P4);
        cyc(6);
        chk("t2 valid before", 32'(v0), 32'd0);
        cyc(1);
        chk_both("t2 frame", 16'h7654, 4'h0, 1'b1, 1'b0);
        cyc(1);
        drive(4'b0000, PO);
        cyc(2);

        // Unknown pattern on digit 2, all-off pattern on digit 0.
        digit(0, PO);
        digit(1, P9);
        digit(2, PX);
        drive(4'b1000, PA);
        cyc(7);
        chk_both("t3 frame", 16'hA09F, 4'b0100, 1'b1, 1'b0);
        cyc(1);
        drive(4'b0000, PO);
        cyc(2);

        // Back-pressure: second frame is dropped with a single overrun pulse.
        ready = 1'b0;
        digit(0, PB);
        digit(1, PC);
        digit(2, PD);
        drive(4'b1000, PE);
        cyc(7);
        chk_both("t4 first frame", 16'hEDCB, 4'h0, 1'b1, 1'b0);
        cyc(1);
        drive(4'b0000, PO);
        cyc(2);
        digit(0, P0);
        digit(1, P5);
        digit(2, P6);
        drive(4'b1000, P7);
        cyc(6);
        chk_both("t4 before drop", 16'hEDCB, 4'h0, 1'b1, 1'b0);
        cyc(1);
        chk_both("t4 drop pulse", 16'hEDCB, 4'h0, 1'b1, 1'b1);
        cyc(1);
        chk_both("t4 after drop", 16'hEDCB, 4'h0, 1'b1, 1'b0);
        drive(4'b0000, PO);
        cyc(2);
        ready = 1'b1;
        cyc(1);
        chk_both("t4 transfer", 16'hEDCB, 4'h0, 1'b0, 1'b0);

        // Multi-hot strobe must not capture into any slot.
        digit(0, P1);
        digit(1, P2);
        digit(2, P3);
        drive(4'b0011, P5);
        cyc(10);
        chk("t5 multihot no frame", 32'(v0), 32'd0);
        chk("t5 ca multihot no frame", 32'(v1), 32'd0);
        drive(4'b0000, PO);
        cyc(2);
        drive(4'b1000, P4);
        cyc(7);
        chk_both("t5 frame", 16'h4321, 4'h0, 1'b1, 1'b0);
        cyc(1);
        drive(4'b0000, PO);
        cyc(2);

        // Reset after two captures discards the partial frame.
        digit(0, P8);
        digit(1, P9);
        rst_n = 1'b0;
        #1;
        chk_both("t6 in reset", 16'h0000, 4'h0, 1'b0, 1'b0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        digit(2, P7);
        digit(3, P8);
        chk_both("t6 partial discarded", 16'h0000, 4'h0, 1'b0, 1'b0);
        digit(0, P5);
        drive(4'b0010, P6);
        cyc(6);
        chk_both("t6 before frame", 16'h0000, 4'h0, 1'b0, 1'b0);
        cyc(1);
        chk_both("t6 frame", 16'h8765, 4'h0, 1'b1, 1'b0);
        cyc(1);
        chk_both("t6 after transfer", 16'h8765, 4'h0, 1'b0, 1'b0);
        drive(4'b0000, PO);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
